// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router packet generator.
//   state_t       - generator FSM states
//   MAX_LEN       - largest legal payload length in bytes
//   LEN_W         - width of the payload length / byte counter
//   ILLEGAL_DEST  - destination code that has no router port behind it
//   LFSR_TAPS     - Galois tap mask for x^8+x^6+x^5+x^4+1 (right-shifting)
//   lfsr_fix_seed - maps the all-zero seed (a lock-up state) to 0x01
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  localparam int         MAX_LEN      = 63;
  localparam int         LEN_W        = $clog2(MAX_LEN + 1);
  localparam logic [1:0] ILLEGAL_DEST = 2'b11;
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;

  function automatic logic [7:0] lfsr_fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/router_lfsr8.sv
// router_lfsr8: 8-bit Galois LFSR used as the pseudo-random payload source.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   load  - load the (zero-corrected) seed; has priority over adv
//   adv   - advance one LFSR step
//   seed  - seed value used on load
//   state - current LFSR state
module router_lfsr8
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= 8'h01;
    end else if (load) begin
      state <= lfsr_fix_seed(seed);
    end else if (adv) begin
      state <= {1'b0, state[7:1]} ^ (state[0] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/router_pkt_gen.sv
// router_pkt_gen: builds one router packet per accepted request:
//   header {len,dest} -> len payload bytes -> parity byte -> GAP_CYC idle cycles.
// Ports:
//   clk, rst          - clock and asynchronous active-low reset
//   start             - packet request, honoured only while ready=1
//   dest, len         - destination (0..2) and payload length (1..63)
//   mode, seed        - payload source (0 count from seed, 1 LFSR) and its seed
//   inj_err           - send the parity byte inverted
//   busy              - router stall; a byte moves only on edges with busy=0
//   pkt_valid         - high on header/payload bytes
//   data_out          - byte to router
//   ready             - high while idle
//   done, cfg_err     - one-cycle pulses: packet finished / request rejected
//   pkt_cnt           - completed packet count (wraps)
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int GAP_CYC = 1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       dest,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic [7:0]       seed,
  input  logic             inj_err,
  input  logic             busy,
  output logic             pkt_valid,
  output logic [7:0]       data_out,
  output logic             ready,
  output logic             done,
  output logic             cfg_err,
  output logic [15:0]      pkt_cnt
);

  state_t           state, state_n;
  logic [1:0]       dest_q, dest_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             mode_q, mode_n;
  logic [7:0]       seed_q, seed_n;
  logic             inj_q, inj_n;
  logic [7:0]       parity, parity_n;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_n;
  logic [3:0]       gap_cnt, gap_n;
  logic [7:0]       data_n;
  logic             valid_n, ready_n, done_n, cfg_err_n;
  logic [15:0]      cnt_n;
  logic             lfsr_load, lfsr_adv;
  logic [7:0]       lfsr_q, gen_byte, acc_parity;

  router_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .seed  (seed),
    .state (lfsr_q)
  );

  // byte_cnt is the index of the next payload byte to place on data_out;
  // the LFSR is kept in step with it so both sources yield byte k together.
  assign gen_byte   = mode_q ? lfsr_q : (seed_q + 8'(byte_cnt));
  // Parity including the byte currently on data_out (it is being accepted).
  assign acc_parity = parity ^ data_out;

  always_comb begin
    state_n    = state;
    dest_n     = dest_q;
    len_n      = len_q;
    mode_n     = mode_q;
    seed_n     = seed_q;
    inj_n      = inj_q;
    parity_n   = parity;
    byte_cnt_n = byte_cnt;
    gap_n      = gap_cnt;
    data_n     = data_out;
    valid_n    = pkt_valid;
    done_n     = 1'b0;
    cfg_err_n  = 1'b0;
    cnt_n      = pkt_cnt;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && ready) begin
          if (dest == ILLEGAL_DEST || len == '0) begin
            cfg_err_n = 1'b1;
          end else begin
            dest_n     = dest;
            len_n      = len;
            mode_n     = mode;
            seed_n     = seed;
            inj_n      = inj_err;
            parity_n   = 8'h00;
            byte_cnt_n = '0;
            lfsr_load  = 1'b1;
            data_n     = {len, dest};
            valid_n    = 1'b1;
            state_n    = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          parity_n   = acc_parity;
          data_n     = gen_byte;
          byte_cnt_n = byte_cnt + 1'b1;
          lfsr_adv   = 1'b1;
          state_n    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          parity_n = acc_parity;
          if (byte_cnt == len_q) begin
            data_n  = acc_parity ^ {8{inj_q}};
            valid_n = 1'b0;
            state_n = S_PARITY;
          end else begin
            data_n     = gen_byte;
            byte_cnt_n = byte_cnt + 1'b1;
            lfsr_adv   = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          data_n  = 8'h00;
          gap_n   = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'(GAP_CYC - 1)) begin
          done_n  = 1'b1;
          cnt_n   = pkt_cnt + 16'd1;
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      seed_q    <= 8'h00;
      inj_q     <= 1'b0;
      parity    <= 8'h00;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      pkt_cnt   <= 16'h0000;
    end else begin
      state     <= state_n;
      dest_q    <= dest_n;
      len_q     <= len_n;
      mode_q    <= mode_n;
      seed_q    <= seed_n;
      inj_q     <= inj_n;
      parity    <= parity_n;
      byte_cnt  <= byte_cnt_n;
      gap_cnt   <= gap_n;
      data_out  <= data_n;
      pkt_valid <= valid_n;
      ready     <= ready_n;
      done      <= done_n;
      cfg_err   <= cfg_err_n;
      pkt_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_router_pkt_gen.sv
// tb_router_pkt_gen: self-checking bench for router_pkt_gen.
// A packet-level model builds the expected byte list (header, payload,
// parity) from the request fields; the bench then walks that list cycle by
// cycle, moving to the next byte only on edges where it drove busy=0.
module tb_router_pkt_gen;

  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  dest;
  logic [5:0]  len;
  logic        mode;
  logic [7:0]  seed;
  logic        inj_err;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  data_out;
  logic        ready;
  logic        done;
  logic        cfg_err;
  logic [15:0] pkt_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'h0000;
  logic [7:0]  exp_q[$];

  router_pkt_gen #(.GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .mode      (mode),
    .seed      (seed),
    .inj_err   (inj_err),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .ready     (ready),
    .done      (done),
    .cfg_err   (cfg_err),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected packet: header, payload bytes, parity (last entry).
  task automatic build_expected(input logic [1:0] d, input logic [5:0] l, input logic m,
                                input logic [7:0] s, input logic ie);
    int         hdr, par, cur;
    exp_q.delete();
    hdr = l * 4 + d;
    exp_q.push_back(8'(hdr));
    par = hdr;
    cur = (s == 0) ? 1 : s;
    for (int k = 0; k < l; k++) begin
      int b;
      if (m == 1'b0) begin
        b = (s + k) % 256;
      end else begin
        b = cur;
        // Galois step: shift right, fold in the taps when a one falls out.
        cur = (cur % 2 == 1) ? ((cur / 2) ^ 8'hB8) : (cur / 2);
      end
      exp_q.push_back(8'(b));
      par = par ^ b;
    end
    if (ie) par = par ^ 8'hFF;
    exp_q.push_back(8'(par));
  endtask

  task automatic drive_garbage();
    start   = 1'($urandom);
    dest    = 2'($urandom);
    len     = 6'($urandom);
    mode    = 1'($urandom);
    seed    = 8'($urandom);
    inj_err = 1'($urandom);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 16'(ready), 16'd1);
  endtask

  // Run one legal packet and check every cycle up to and including done.
  task automatic run_pkt(input string tag, input logic [1:0] d, input logic [5:0] l,
                         input logic m, input logic [7:0] s, input logic ie,
                         input int stall_pos, input int stall_len, input int busy_pct);
    int p = 0;
    int stall_left = 0;
    int cyc = 0;
    bit stalled = 0;
    int last;
    build_expected(d, l, m, s, ie);
    last = exp_q.size() - 1;
    wait_ready(tag);
    start = 1'b1; dest = d; len = l; mode = m; seed = s; inj_err = ie; busy = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    while (p <= last && cyc < 2000) begin
      check({tag, "_data"},  16'(data_out),  16'(exp_q[p]));
      check({tag, "_valid"}, 16'(pkt_valid), 16'(p != last));
      check({tag, "_ready"}, 16'(ready),     16'd0);
      check({tag, "_done"},  16'(done),      16'd0);
      if (p == stall_pos && !stalled) begin
        stalled = 1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        busy = 1'b1;
        stall_left--;
      end else begin
        busy = ($urandom_range(99) < busy_pct);
      end
      drive_garbage();
      @(posedge clk);
      if (!busy) p++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_stream_end"}, 16'(p), 16'(last + 1));
    for (int g = 0; g < GAP; g++) begin
      check({tag, "_gap_data"},  16'(data_out),  16'd0);
      check({tag, "_gap_valid"}, 16'(pkt_valid), 16'd0);
      check({tag, "_gap_done"},  16'(done),      16'd0);
      busy = 1'($urandom);
      drive_garbage();
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    busy  = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_done_pulse"}, 16'(done),      16'd1);
    check({tag, "_done_ready"}, 16'(ready),     16'd1);
    check({tag, "_done_valid"}, 16'(pkt_valid), 16'd0);
    check({tag, "_pkt_cnt"},    pkt_cnt,        exp_cnt);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_once"},  16'(done),      16'd0);
  endtask

  task automatic reject(input string tag, input logic [1:0] d, input logic [5:0] l);
    wait_ready(tag);
    start = 1'b1; dest = d; len = l; mode = 1'b0; seed = 8'h5A; inj_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_cfg_err"}, 16'(cfg_err),   16'd1);
    check({tag, "_ready"},   16'(ready),     16'd1);
    check({tag, "_valid"},   16'(pkt_valid), 16'd0);
    check({tag, "_data"},    16'(data_out),  16'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_cfg_once"}, 16'(cfg_err),   16'd0);
    check({tag, "_valid2"},   16'(pkt_valid), 16'd0);
    check({tag, "_pkt_cnt"},  pkt_cnt,        exp_cnt);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dest = 2'd0; len = 6'd0; mode = 1'b0;
    seed = 8'h00; inj_err = 1'b0; busy = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",   16'(pkt_valid), 16'd0);
    check("rst_data",    16'(data_out),  16'd0);
    check("rst_done",    16'(done),      16'd0);
    check("rst_cfg_err", 16'(cfg_err),   16'd0);
    check("rst_pkt_cnt", pkt_cnt,        16'h0000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 16'(ready), 16'd1);

    // Basic packet, stalled packet, injected parity error
    run_pkt("basic",  2'd1, 6'd4, 1'b0, 8'hA0, 1'b0, -1, 0, 0);
    run_pkt("stall",  2'd1, 6'd4, 1'b0, 8'hA0, 1'b0,  2, 3, 0);
    run_pkt("injerr", 2'd1, 6'd4, 1'b0, 8'hA0, 1'b1, -1, 0, 0);

    // Rejected requests
    reject("bad_dest", 2'd3, 6'd5);
    reject("bad_len",  2'd2, 6'd0);

    // LFSR payloads, including the zero seed and the longest packet
    run_pkt("lfsr_s0",  2'd0, 6'd10, 1'b1, 8'h00, 1'b0, -1, 0, 0);
    run_pkt("lfsr_max", 2'd2, 6'd63, 1'b1, 8'hC3, 1'b0, -1, 0, 20);
    run_pkt("cnt_wrap", 2'd2, 6'd20, 1'b0, 8'hF8, 1'b1, -1, 0, 0);

    // Randomized packets with random stalls
    for (int i = 0; i < 25; i++) begin
      run_pkt("rand", 2'($urandom_range(2)), 6'($urandom_range(63, 1)), 1'($urandom),
              8'($urandom), 1'($urandom), -1, 0, 30);
    end

    // Reset in the middle of a long payload
    wait_ready("abort");
    start = 1'b1; dest = 2'd2; len = 6'd63; mode = 1'b0; seed = 8'h10; inj_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_mid_valid", 16'(pkt_valid), 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid",   16'(pkt_valid), 16'd0);
    check("abort_data",    16'(data_out),  16'd0);
    check("abort_done",    16'(done),      16'd0);
    check("abort_pkt_cnt", pkt_cnt,        16'h0000);
    exp_cnt = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", 16'(ready), 16'd1);
    check("abort_nodone", 16'(done), 16'd0);
    run_pkt("after_abort", 2'd0, 6'd7, 1'b1, 8'h3C, 1'b0, -1, 0, 25);

    // Packet counter wrap
    force dut.pkt_cnt = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.pkt_cnt;
    @(posedge clk);
    @(negedge clk);
    check("wrap_preload", pkt_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_pkt("wrap", 2'd1, 6'd1, 1'b0, 8'h77, 1'b0, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_gen.md
ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

Interface
REQ-001 Parameter GAP_CYC, default 1: idle cycles inserted after each parity byte; legal range 1..15.
REQ-002 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-low; the clock and reset are clk and rst; no other clock or reset exists.
REQ-004 Port start, input, 1: packet request; sampled only while ready=1.
REQ-005 Port dest, input, 2: destination port 0..2; value 3 is illegal.
REQ-006 Port len, input, 6: payload length in bytes, 1..63; value 0 is illegal.
REQ-007 Port mode, input, 1: payload source; 0 = incrementing count from seed, 1 = LFSR seeded from seed.
REQ-008 Port seed, input, 8: first payload byte (mode 0) or LFSR seed (mode 1).
REQ-009 Port inj_err, input, 1: when 1, the parity byte is sent bit-inverted.
REQ-010 Port busy, input, 1: router stall; a byte transfers only at an edge where busy=0.
REQ-011 Port pkt_valid, output, 1: high during the header and payload bytes, low during the parity byte.
REQ-012 Port data_out, output, 8: byte driven to the router data_in.
REQ-013 Port ready, output, 1: high only in IDLE.
REQ-014 Port done, output, 1: one-cycle pulse when a packet completes.
REQ-015 Port cfg_err, output, 1: one-cycle pulse when a start is rejected.
REQ-016 Port pkt_cnt, output, 16: count of completed packets; wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP; all outputs are registered.
REQ-018 IDLE + start with dest<3 and len>0: capture dest/len/mode/seed/inj_err -> HEADER next cycle.
REQ-019 IDLE + start with dest=3 or len=0: cfg_err pulse next cycle; remain in IDLE; no byte driven.
REQ-020 HEADER: data_out={len,dest}, pkt_valid=1; busy=0 at edge -> PAYLOAD.
REQ-021 PAYLOAD: byte k (k=0..len-1) is seed+k mod 256 (mode 0) or LFSR state k (mode 1, state0=seed, x^8+x^6+x^5+x^4+1 Galois, seed 0 forced to 0x01).
REQ-022 PAYLOAD: pkt_valid=1; the byte counter and generator advance only at edges with busy=0; the last byte accepted -> PARITY.
REQ-023 Running parity = XOR of the header and all payload bytes, updated only on accepted bytes.
REQ-024 PARITY: pkt_valid=0, data_out=parity (inverted if inj_err); busy=0 at edge -> GAP.
REQ-025 GAP: pkt_valid=0, data_out=0 for GAP_CYC cycles; on the last cycle pulse done, increment pkt_cnt, -> IDLE.
REQ-026 Under busy=1, data_out and pkt_valid hold their values unchanged for any number of cycles.
REQ-027 start while ready=0 is ignored; captured fields do not change mid-packet.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, pkt_valid=0, data_out=0x00, done=0, cfg_err=0, pkt_cnt=0, parity=0, counters=0; ready=1 from the first edge after release.
REQ-029 Reset mid-packet abandons the packet; no done pulse and no pkt_cnt change for the abandoned packet.

Structure
REQ-030 Shared package router_pkg holds: state enum, MAX_LEN=63, ILLEGAL_DEST=2'b11, LFSR tap constant 8'hB8.
REQ-031 A single sub-module, router_lfsr8, holds the 8-bit LFSR with load and advance-enable inputs.

Verification
REQ-032 dest=1, len=4, mode 0, seed 0xA0, busy=0 -> bytes 0x11,A0,A1,A2,A3 with pkt_valid=1, then 0x11 with pkt_valid=0; done pulse after 1 gap cycle; pkt_cnt=1.
REQ-033 Same packet with busy=1 for 3 cycles during payload byte A1 -> A1 held for 4 cycles; the stream is otherwise identical.
REQ-034 inj_err=1 with the REQ-032 packet -> parity byte 0xEE.
REQ-035 start with dest=3, then start with len=0 -> one cfg_err pulse for each, ready stays 1, pkt_valid never rises.
REQ-036 rst=0 asserted mid-PAYLOAD of len=63 -> outputs zero immediately; the next packet is correct; pkt_cnt excludes the aborted packet.
REQ-037 Preload pkt_cnt to 0xFFFF via 65535 packets with len=1 (or force), then one more packet -> pkt_cnt=0x0000.
